// File: rtl/count_sequencer.sv
// count_sequencer: run/pause/done sequencer for a single decimal digit.
//
// A prescaler gates counting so the count advances once every DIV clocks while
// running. The current count is decoded to a 7-segment pattern.
//
// Optional feature (macro COUNT_DOWN_EN): adds the 'dir' input. When dir is 1
// at run entry, the count loads MAXV and counts down, with 0 as the terminal value.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   level: begin / resume counting (also restarts from DONE)
//   pause     in   level: freeze while running
//   clear     in   level: return to idle, count = 0 (highest priority)
//   mode_wrap in   1 = wrap at terminal value, 0 = stop in DONE
//   dir       in   (COUNT_DOWN_EN only) 1 = count down; latched at run entry
//   q         out  current count
//   dout      out  segments {g,f,e,d,c,b,a}, 1 = lit
//   state     out  0 idle, 1 run, 2 pause, 3 done
//   done      out  one-cycle pulse when the terminal value stops the count
module count_sequencer #(
  parameter int unsigned DIV  = 4,
  parameter int unsigned MAXV = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       mode_wrap,
`ifdef COUNT_DOWN_EN
  input  logic       dir,
`endif
  output logic [3:0] q,
  output logic [6:0] dout,
  output logic [1:0] state,
  output logic       done
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [3:0] MaxQ = 4'(MAXV);
  localparam logic [PW-1:0] LastP = PW'(DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    q_q, q_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          down_q, down_d;

  logic dir_in;
`ifdef COUNT_DOWN_EN
  assign dir_in = dir;
`else
  assign dir_in = 1'b0;
`endif

  logic       tick;
  logic       at_term;
  logic [3:0] entry_q;

  assign tick    = (presc_q == LastP);
  assign at_term = down_q ? (q_q == 4'd0) : (q_q == MaxQ);
  // Value loaded when a run starts from idle or restarts from done.
  assign entry_q = dir_in ? MaxQ : 4'd0;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    down_d  = down_q;
    if (clear) begin
      state_d = StIdle;
      q_d     = 4'd0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StRun;
            presc_d = '0;
            q_d     = entry_q;
            down_d  = dir_in;
          end
        end
        StRun: begin
          // start outranks pause, so start+pause keeps running.
          if (pause && !start) begin
            state_d = StPause;
          end else if (tick) begin
            presc_d = '0;
            if (!at_term) begin
              q_d = down_q ? (q_q - 4'd1) : (q_q + 4'd1);
            end else if (mode_wrap) begin
              q_d = down_q ? MaxQ : 4'd0;
            end else begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        StPause: begin
          if (start) begin
            state_d = StRun;
          end
        end
        StDone: begin
          if (start) begin
            state_d = StRun;
            presc_d = '0;
            q_d     = entry_q;
            down_d  = dir_in;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      q_q     <= 4'd0;
      presc_q <= '0;
      done_q  <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      presc_q <= presc_d;
      done_q  <= done_d;
      down_q  <= down_d;
    end
  end

  always_comb begin
    case (q_q)
      4'd0:    dout = 7'h3F;
      4'd1:    dout = 7'h06;
      4'd2:    dout = 7'h5B;
      4'd3:    dout = 7'h4F;
      4'd4:    dout = 7'h66;
      4'd5:    dout = 7'h6D;
      4'd6:    dout = 7'h7D;
      4'd7:    dout = 7'h07;
      4'd8:    dout = 7'h7F;
      4'd9:    dout = 7'h6F;
      default: dout = 7'h00;
    endcase
  end

  assign q     = q_q;
  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

  localparam int unsigned DIV  = 4;
  localparam int unsigned MAXV = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, pause = 1'b0, clear = 1'b0, mode_wrap = 1'b0, dir = 1'b0;
  logic [3:0] q;
  logic [6:0] dout;
  logic [1:0] state;
  logic       done;

  int checks = 0;
  int passes = 0;

  // Reference model: state number, count, prescaler phase, done pulse, direction.
  int m_st, m_q, m_p;
  bit m_done, m_down;

  always #5 clk = ~clk;

  count_sequencer #(
    .DIV (DIV),
    .MAXV(MAXV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .mode_wrap(mode_wrap),
`ifdef COUNT_DOWN_EN
    .dir      (dir),
`endif
    .q        (q),
    .dout     (dout),
    .state    (state),
    .done     (done)
  );

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [13:0] expv();
    return {4'(m_q), 2'(m_st), m_done, seg(m_q)};
  endfunction

  function automatic void model_reset();
    m_st = 0; m_q = 0; m_p = 0; m_done = 0; m_down = 0;
  endfunction

  // One clock of the command rules: clear > start > pause; one tick per DIV cycles.
  function automatic void model_step();
    int nst = m_st, nq = m_q, np = m_p, term;
    bit nd = 0, use_dir;
`ifdef COUNT_DOWN_EN
    use_dir = dir;
`else
    use_dir = 0;
`endif
    if (clear) begin
      nst = 0; nq = 0; np = 0;
    end else if ((m_st == 0 || m_st == 3) && start) begin
      nst = 1; np = 0; m_down = use_dir; nq = use_dir ? MAXV : 0;
    end else if (m_st == 2 && start) begin
      nst = 1;
    end else if (m_st == 1 && pause && !start) begin
      nst = 2;
    end else if (m_st == 1) begin
      np = (m_p + 1) % DIV;
      if (m_p == DIV - 1) begin
        term = m_down ? 0 : MAXV;
        if (m_q != term) nq = m_down ? m_q - 1 : m_q + 1;
        else if (mode_wrap) nq = MAXV - term;
        else begin nst = 3; nd = 1; end
      end
    end
    m_st = nst; m_q = nq; m_p = np; m_done = nd;
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run_until(input int tq, input int tp, input string nm);
    int n = 0;
    while (!(m_q == tq && (tp < 0 || m_p == tp)) && n < 200) begin
      cycle();
      n++;
    end
    if (!(m_q == tq && (tp < 0 || m_p == tp))) begin
      checks++;
      $display("FAIL %s_timeout got q=%0d p=%0d want q=%0d p=%0d", nm, m_q, m_p, tq, tp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    if ({q, state, done, dout} !== {4'd0, 2'd0, 1'b0, 7'h3F})
      $display("FAIL reset_initial got=%h want=%h", {q, state, done, dout},
               {4'd0, 2'd0, 1'b0, 7'h3F});
    else passes++;
    checks++;
    #1 reset = 1'b1;
    model_reset();
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_until(5, -1, "reset_run");
    if ({q, state} !== {4'd5, 2'd1})
      $display("FAIL reset_prerun got q=%0d st=%0d want q=5 st=1", q, state);
    else passes++;
    checks++;
    reset = 1'b0;
    #1;
    if ({q, state, done, dout} !== {4'd0, 2'd0, 1'b0, 7'h3F})
      $display("FAIL reset_async got=%h want=%h", {q, state, done, dout},
               {4'd0, 2'd0, 1'b0, 7'h3F});
    else passes++;
    checks++;
    model_reset();
    #1 reset = 1'b1;
  endtask

  task automatic test_count_up();
    int ndone = 0;
    mode_wrap = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < DIV * (MAXV + 1) + 5; i++) begin
      cycle();
      if (done === 1'b1) ndone++;
      if ({q, state, done, dout} !== expv())
        $display("FAIL count_up cyc=%0d got=%h want=%h", i, {q, state, done, dout}, expv());
      else passes++;
      checks++;
    end
    if (ndone !== 1) $display("FAIL count_up_done_pulses got=%0d want=1", ndone);
    else passes++;
    checks++;
    if ({q, state, dout} !== {4'd9, 2'd3, 7'h6F})
      $display("FAIL count_up_final got q=%0d st=%0d dout=%h want q=9 st=3 dout=6f",
               q, state, dout);
    else passes++;
    checks++;
  endtask

  task automatic test_pause_resume();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_until(3, 2, "pause_run");
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if ({q, state} !== {4'd3, 2'd2} || {q, state, done, dout} !== expv())
        $display("FAIL pause_hold cyc=%0d got=%h want=%h", i, {q, state, done, dout}, expv());
      else passes++;
      checks++;
    end
    pause = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if ({q, state} !== {4'd3, 2'd1})
        $display("FAIL resume_wait cyc=%0d got q=%0d st=%0d want q=3 st=1", i, q, state);
      else passes++;
      checks++;
      cycle();
    end
    if ({q, state, done, dout} !== {4'd4, 2'd1, 1'b0, 7'h66} || m_q != 4)
      $display("FAIL resume_incr got=%h want=%h", {q, state, done, dout},
               {4'd4, 2'd1, 1'b0, 7'h66});
    else passes++;
    checks++;
  endtask

  task automatic test_wrap();
    int ndone = 0;
    bit saw_wrap = 0;
    logic [3:0] prev;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    mode_wrap = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    prev = q;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (done === 1'b1) ndone++;
      if (prev == 4'd9 && q == 4'd0 && state == 2'd1) saw_wrap = 1;
      prev = q;
      if ({q, state, done, dout} !== expv())
        $display("FAIL wrap cyc=%0d got=%h want=%h", i, {q, state, done, dout}, expv());
      else passes++;
      checks++;
    end
    if (!saw_wrap || ndone != 0)
      $display("FAIL wrap_summary got wrap=%0b done_cnt=%0d want wrap=1 done_cnt=0",
               saw_wrap, ndone);
    else passes++;
    checks++;
    mode_wrap = 1'b0;
  endtask

  task automatic test_priority();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    run_until(6, -1, "prio_run");
    {clear, start, pause} = 3'b111;
    cycle();
    {clear, start, pause} = 3'b000;
    if ({q, state} !== {4'd0, 2'd0})
      $display("FAIL prio_clear got q=%0d st=%0d want q=0 st=0", q, state);
    else passes++;
    checks++;
    start = 1'b1;
    cycle();
    start = 1'b0;
    pause = 1'b1;
    cycle();
    if (state !== 2'd2) $display("FAIL prio_pause got st=%0d want st=2", state);
    else passes++;
    checks++;
    start = 1'b1;
    cycle();
    {start, pause} = 2'b00;
    if ({q, state, done, dout} !== expv() || state !== 2'd1)
      $display("FAIL prio_start_pause got=%h want=%h", {q, state, done, dout}, expv());
    else passes++;
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      clear = ($urandom_range(0, 24) == 0);
      start = ($urandom_range(0, 6) == 0);
      pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) mode_wrap = ~mode_wrap;
      dir = $urandom_range(0, 1);
      cycle();
      if ({q, state, done, dout} !== expv())
        $display("FAIL random cyc=%0d got=%h want=%h", i, {q, state, done, dout}, expv());
      else passes++;
      checks++;
    end
    {clear, start, pause, mode_wrap, dir} = 5'b0;
  endtask

`ifdef COUNT_DOWN_EN
  task automatic test_count_down();
    int ndone = 0;
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    mode_wrap = 1'b0;
    dir = 1'b1;
    start = 1'b1;
    cycle();
    {start, dir} = 2'b00;
    if ({q, state} !== {4'd9, 2'd1})
      $display("FAIL down_entry got q=%0d st=%0d want q=9 st=1", q, state);
    else passes++;
    checks++;
    for (int i = 0; i < DIV * (MAXV + 1) + 5; i++) begin
      cycle();
      if (done === 1'b1) ndone++;
      if ({q, state, done, dout} !== expv())
        $display("FAIL count_down cyc=%0d got=%h want=%h", i, {q, state, done, dout}, expv());
      else passes++;
      checks++;
    end
    if ({q, state} !== {4'd0, 2'd3} || ndone != 1)
      $display("FAIL down_final got q=%0d st=%0d pulses=%0d want q=0 st=3 pulses=1",
               q, state, ndone);
    else passes++;
    checks++;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_count_up();
    test_pause_resume();
    test_wrap();
    test_priority();
`ifdef COUNT_DOWN_EN
    test_count_down();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
